serial_loader: RTL and testbench
================================

SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 24000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate; bit period DIV = CLK_HZ/BAUD rounded to nearest (208 at defaults).
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port RxPin  input  1  UART receive line, 8N1, idle high, asynchronous to clk.
REQ-006 SHALL have port WriteAddress  output  11  BRAM byte address for the current write.
REQ-007 SHALL have port WriteDATA  output  8  byte to write.
REQ-008 SHALL have port WriteEnable  output  1  one-cycle write strobe; WriteAddress/WriteDATA valid in the same cycle.
REQ-009 SHALL have port FrameDone  output  1  one-cycle pulse on a correctly terminated record.
REQ-010 SHALL have port FrameError  output  1  one-cycle pulse on any protocol or framing error.
REQ-011 SHALL have port ErrCount  output  8  error counter (see Configuration).

Function
REQ-012 SHALL synchronise RxPin through two flip-flops before any use.
REQ-013 SHALL detect a start bit on a synchronised high-to-low transition while the bit receiver is idle; SHALL re-sample at DIV/2 and abort (no byte, no error) if the line is high.
REQ-014 SHALL sample the 8 data bits LSB first at DIV-cycle intervals from the start-bit centre, then the stop bit.
REQ-015 SHALL discard a byte whose stop bit samples 0 and pulse FrameError; parser state SHALL return to IDLE.
REQ-016 SHALL pass each good byte to the parser as a one-cycle valid pulse at the stop-bit sample.
REQ-017 Parser states: IDLE, ADDR, HASH, DATA_HI, DATA_LO.
REQ-018 IDLE: "$" -> ADDR with digit counter 0; any other byte ignored, no error.
REQ-019 ADDR: hex digit shifts left-4 into a 16-bit address shift register; after the 4th digit -> HASH.
REQ-020 HASH: "#" -> DATA_HI, load write address from shift register bits [10:0]; bits [15:11] ignored.
REQ-021 DATA_HI: hex digit stored as high nibble -> DATA_LO; " " stays in DATA_HI; CR (8'd13) pulses FrameDone -> IDLE.
REQ-022 DATA_LO: hex digit completes the byte -> DATA_HI; WriteEnable pulses the cycle after the digit is accepted.
REQ-023 Write address SHALL increment by 1 the cycle after each WriteEnable, wrapping 11'h7FF -> 11'h000.
REQ-024 Hex digits SHALL be "0"-"9", "A"-"F", "a"-"f".
REQ-025 In ADDR, HASH, DATA_HI, DATA_LO any unexpected byte SHALL pulse FrameError -> IDLE, except "$", which restarts ADDR with no error.
REQ-026 CR in DATA_LO (odd digit count) SHALL be an error; the half byte SHALL NOT be written.
REQ-027 FrameError and WriteEnable SHALL never assert in the same cycle.

Reset
REQ-028 RESET SHALL force parser to IDLE, bit receiver to idle, sync flops to 1, and WriteAddress=0, WriteDATA=0, WriteEnable=0, FrameDone=0, FrameError=0, ErrCount=0.
REQ-029 RESET mid-byte or mid-record SHALL drop the partial byte/record with no write and no pulse.

Configuration
REQ-030 With SERIAL_LOADER_ERRCNT_EN defined, ErrCount SHALL increment on each FrameError pulse, saturating at 8'hFF.
REQ-031 Without SERIAL_LOADER_ERRCNT_EN, ErrCount SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-032 "$0010#AB cd\r" at 115200 -> WriteEnable at 0x010 data 0xAB, at 0x011 data 0xCD, then one FrameDone; no FrameError.
REQ-033 "$07FF#1122\r" -> writes 0x7FF=0x11, 0x000=0x22 (wrap).
REQ-034 "$00G" -> FrameError pulse on "G", no writes; ErrCount=1 with macro, 0 without.
REQ-035 Byte with stop bit 0 during DATA_HI -> FrameError, parser IDLE, following "12\r" ignored (no writes).
REQ-036 "$0100#5" then RESET asserted, released, then "$0200#66\r" -> single write 0x200=0x66, no FrameError.
REQ-037 0.5-bit low glitch on RxPin while idle -> no byte, no pulse; "$0000#3\r" -> FrameError, no write.

Source files
------------

// File: rtl/serial_loader.sv
// serial_loader -- UART-fed BRAM loader.
//
// An 8N1 UART receiver feeds a text-record parser. A record has the form
// "$AAAA#DD DD...\r": four hex address digits, '#', then hex byte pairs
// with optional spaces, then CR. Each completed byte is written to BRAM
// and the write address then advances by one, wrapping at 11 bits.
//
// Parameters:
//   CLK_HZ  system clock frequency in Hz
//   BAUD    UART bit rate; bit period DIV = round(CLK_HZ / BAUD)
//
// Ports:
//   clk           system clock, rising edge
//   RESET         asynchronous active-high reset
//   RxPin         UART receive line, idle high, asynchronous to clk
//   WriteAddress  BRAM byte address for the current write
//   WriteDATA     byte to write
//   WriteEnable   one-cycle write strobe
//   FrameDone     one-cycle pulse on a correctly terminated record
//   FrameError    one-cycle pulse on a protocol or framing error
//   ErrCount      saturating FrameError counter
//
// Build option:
//   SERIAL_LOADER_ERRCNT_EN  when defined, ErrCount counts FrameError
//                            pulses (saturating at 8'hFF); otherwise
//                            ErrCount is tied to zero.

module serial_loader #(
  parameter int unsigned CLK_HZ = 24000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        RxPin,
  output logic [10:0] WriteAddress,
  output logic [7:0]  WriteDATA,
  output logic        WriteEnable,
  output logic        FrameDone,
  output logic        FrameError,
  output logic [7:0]  ErrCount
);

  localparam int unsigned DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_CR     = 8'h0D;

  // ------------------------------------------------------------------
  // Input synchroniser and falling-edge history
  // ------------------------------------------------------------------
  logic rx_meta, rx_s, rx_prev;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RxPin;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // ------------------------------------------------------------------
  // Bit receiver
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic          rx_valid, rx_ferr;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rx_sh    <= '0;
    end else begin
      rx_state <= rx_state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      rx_sh    <= rx_sh_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    cnt_n      = cnt + CW'(1);
    bit_idx_n  = bit_idx;
    rx_sh_n    = rx_sh;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_s) rx_state_n = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          // Line back high at mid start bit: a glitch, silently dropped.
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == DIV_LAST) begin
          cnt_n     = '0;
          rx_sh_n   = {rx_s, rx_sh[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == DIV_LAST) begin
          cnt_n      = '0;
          rx_state_n = RX_IDLE;
          if (rx_s) rx_valid = 1'b1;
          else      rx_ferr  = 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Record parser
  // ------------------------------------------------------------------
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_HASH, P_DATA_HI, P_DATA_LO} p_state_t;

  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66)) r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

  p_state_t    pstate, pstate_n;
  logic [1:0]  dcnt, dcnt_n;
  // Only the low 11 address bits are ever loaded, so the shift register
  // keeps just those; the upper digits shift out without effect.
  logic [10:0] asr, asr_n;
  logic [3:0]  hi_nib, hi_nib_n;
  logic [7:0]  wdata_n;
  logic        we_n, done_n, err_n, load_addr;
  logic [4:0]  hex;

  assign hex = hex_decode(rx_sh);

  always_comb begin
    pstate_n  = pstate;
    dcnt_n    = dcnt;
    asr_n     = asr;
    hi_nib_n  = hi_nib;
    wdata_n   = WriteDATA;
    we_n      = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    load_addr = 1'b0;
    if (rx_ferr) begin
      err_n    = 1'b1;
      pstate_n = P_IDLE;
    end else if (rx_valid) begin
      if (pstate != P_IDLE && rx_sh == CH_DOLLAR) begin
        pstate_n = P_ADDR;
        dcnt_n   = '0;
      end else begin
        unique case (pstate)
          P_IDLE: begin
            if (rx_sh == CH_DOLLAR) begin
              pstate_n = P_ADDR;
              dcnt_n   = '0;
            end
          end
          P_ADDR: begin
            if (hex[4]) begin
              asr_n  = {asr[6:0], hex[3:0]};
              dcnt_n = dcnt + 2'd1;
              if (dcnt == 2'd3) pstate_n = P_HASH;
            end else begin
              err_n    = 1'b1;
              pstate_n = P_IDLE;
            end
          end
          P_HASH: begin
            if (rx_sh == CH_HASH) begin
              load_addr = 1'b1;
              pstate_n  = P_DATA_HI;
            end else begin
              err_n    = 1'b1;
              pstate_n = P_IDLE;
            end
          end
          P_DATA_HI: begin
            if (hex[4]) begin
              hi_nib_n = hex[3:0];
              pstate_n = P_DATA_LO;
            end else if (rx_sh == CH_CR) begin
              done_n   = 1'b1;
              pstate_n = P_IDLE;
            end else if (rx_sh != CH_SPACE) begin
              err_n    = 1'b1;
              pstate_n = P_IDLE;
            end
          end
          P_DATA_LO: begin
            if (hex[4]) begin
              we_n     = 1'b1;
              wdata_n  = {hi_nib, hex[3:0]};
              pstate_n = P_DATA_HI;
            end else begin
              err_n    = 1'b1;
              pstate_n = P_IDLE;
            end
          end
          default: pstate_n = P_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      pstate       <= P_IDLE;
      dcnt         <= '0;
      asr          <= '0;
      hi_nib       <= '0;
      WriteDATA    <= '0;
      WriteEnable  <= 1'b0;
      FrameDone    <= 1'b0;
      FrameError   <= 1'b0;
      WriteAddress <= '0;
    end else begin
      pstate      <= pstate_n;
      dcnt        <= dcnt_n;
      asr         <= asr_n;
      hi_nib      <= hi_nib_n;
      WriteDATA   <= wdata_n;
      WriteEnable <= we_n;
      FrameDone   <= done_n;
      FrameError  <= err_n;
      if (load_addr)        WriteAddress <= asr;
      else if (WriteEnable) WriteAddress <= WriteAddress + 11'd1;
    end
  end

  // ------------------------------------------------------------------
  // Error counter
  // ------------------------------------------------------------------
`ifdef SERIAL_LOADER_ERRCNT_EN
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET)                            ErrCount <= '0;
    else if (FrameError && ErrCount != '1) ErrCount <= ErrCount + 8'd1;
  end
`else
  assign ErrCount = '0;
`endif

endmodule

// File: tb/tb_serial_loader.sv
module tb_serial_loader;

  localparam int unsigned CLK_HZ = 1600000;
  localparam int unsigned BAUD   = 100000;
  localparam int unsigned DIV    = 16;

`ifdef SERIAL_LOADER_ERRCNT_EN
  localparam bit EC_EN = 1'b1;
`else
  localparam bit EC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        RxPin = 1'b1;
  logic [10:0] WriteAddress;
  logic [7:0]  WriteDATA;
  logic        WriteEnable, FrameDone, FrameError;
  logic [7:0]  ErrCount;

  serial_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .RESET(RESET), .RxPin(RxPin),
    .WriteAddress(WriteAddress), .WriteDATA(WriteDATA),
    .WriteEnable(WriteEnable), .FrameDone(FrameDone),
    .FrameError(FrameError), .ErrCount(ErrCount)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Event recorder
  logic [10:0] wa [0:63];
  logic [7:0]  wd [0:63];
  int n_wr = 0, n_done = 0, n_err = 0, n_overlap = 0;

  always @(negedge clk) begin
    if (WriteEnable && n_wr < 64) begin
      wa[n_wr] = WriteAddress;
      wd[n_wr] = WriteDATA;
    end
    if (WriteEnable) n_wr++;
    if (FrameDone) n_done++;
    if (FrameError) n_err++;
    if (WriteEnable && FrameError) n_overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    RxPin = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    bit_time(1'b1);
    bit_time(1'b1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  int bw, bd, be;

  task automatic mark;
    bw = n_wr; bd = n_done; be = n_err;
  endtask

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_addr", 32'(WriteAddress), 0);
    chk("rst_data", 32'(WriteDATA), 0);
    chk("rst_we", 32'(WriteEnable), 0);
    chk("rst_done", 32'(FrameDone), 0);
    chk("rst_err", 32'(FrameError), 0);
    chk("rst_ec", 32'(ErrCount), 0);
    RESET = 1'b0;
    repeat (2 * DIV) @(negedge clk);

    // Basic record with space and lower-case digits
    mark();
    send_str("$0010#AB cd\r");
    chk("s1_nwr", 32'(n_wr - bw), 2);
    chk("s1_a0", 32'(wa[bw]), 32'h010);
    chk("s1_d0", 32'(wd[bw]), 32'hAB);
    chk("s1_a1", 32'(wa[bw+1]), 32'h011);
    chk("s1_d1", 32'(wd[bw+1]), 32'hCD);
    chk("s1_done", 32'(n_done - bd), 1);
    chk("s1_err", 32'(n_err - be), 0);
    chk("s1_nextaddr", 32'(WriteAddress), 32'h012);

    // Address wrap
    mark();
    send_str("$07FF#1122\r");
    chk("s2_nwr", 32'(n_wr - bw), 2);
    chk("s2_a0", 32'(wa[bw]), 32'h7FF);
    chk("s2_d0", 32'(wd[bw]), 32'h11);
    chk("s2_a1", 32'(wa[bw+1]), 32'h000);
    chk("s2_d1", 32'(wd[bw+1]), 32'h22);
    chk("s2_done", 32'(n_done - bd), 1);
    chk("s2_err", 32'(n_err - be), 0);
    chk("s2_nextaddr", 32'(WriteAddress), 32'h001);

    // Bad address digit
    mark();
    send_str("$00G");
    chk("s3_err", 32'(n_err - be), 1);
    chk("s3_nwr", 32'(n_wr - bw), 0);
    chk("s3_ec", 32'(ErrCount), EC_EN ? 1 : 0);

    // Stop-bit error in DATA_HI, following digits ignored
    mark();
    send_str("$0000#");
    send_byte(8'h31, 1'b0);
    send_str("12\r");
    chk("s4_err", 32'(n_err - be), 1);
    chk("s4_nwr", 32'(n_wr - bw), 0);
    chk("s4_done", 32'(n_done - bd), 0);
    chk("s4_ec", 32'(ErrCount), EC_EN ? 2 : 0);

    // Reset mid-record and mid-byte
    mark();
    send_str("$0100#5");
    RxPin = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    RESET = 1'b1;
    repeat (2) @(negedge clk);
    RxPin = 1'b1;
    repeat (2) @(negedge clk);
    chk("s5_rst_ec", 32'(ErrCount), 0);
    RESET = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    chk("s5_rst_addr", 32'(WriteAddress), 0);
    chk("s5_rst_nwr", 32'(n_wr - bw), 0);
    chk("s5_rst_err", 32'(n_err - be), 0);
    send_str("$0200#66\r");
    chk("s5_nwr", 32'(n_wr - bw), 1);
    chk("s5_a0", 32'(wa[bw]), 32'h200);
    chk("s5_d0", 32'(wd[bw]), 32'h66);
    chk("s5_done", 32'(n_done - bd), 1);
    chk("s5_err", 32'(n_err - be), 0);

    // Short low glitch while idle, then odd digit count
    mark();
    RxPin = 1'b0;
    repeat (DIV / 2 - 2) @(negedge clk);
    RxPin = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    chk("s6_glitch_err", 32'(n_err - be), 0);
    chk("s6_glitch_wr", 32'(n_wr - bw), 0);
    chk("s6_glitch_done", 32'(n_done - bd), 0);
    send_str("$0000#3\r");
    chk("s6_err", 32'(n_err - be), 1);
    chk("s6_nwr", 32'(n_wr - bw), 0);
    chk("s6_done", 32'(n_done - bd), 0);
    chk("s6_ec", 32'(ErrCount), EC_EN ? 1 : 0);

    chk("we_fe_overlap", 32'(n_overlap), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
